// File: rtl/program_loader.sv
// program_loader: boot-time loader that packs a UART byte stream into RV32I words,
// writes them to instruction memory and releases the core once the image checksum verifies.
module program_loader #(
    parameter int ADDR_W = 14,
    parameter logic [7:0] ACK_OK = 8'hAA,
    parameter logic [7:0] ACK_ERR = 8'h55
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    input  logic              tx_ready,
    output logic              tx_valid,
    output logic [7:0]        tx_data,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              busy,
    output logic              cpu_start,
    output logic              error
);
    typedef enum logic [2:0] {S_LEN, S_DATA, S_CSUM, S_ACK, S_DONE} state_t;
    localparam logic [32:0] MAX_WORDS = 33'd1 << ADDR_W;
    state_t state, state_nx;
    logic [31:0] len, cnt, len_full, word;
    logic [23:0] buf_w;
    logic [7:0] acc;
    logic [1:0] bidx;
    logic ok_r, len_bad, last_word;
    assign len_full  = {rx_data, len[31:8]};
    assign word      = {rx_data, buf_w};
    assign len_bad   = {1'b0, len_full} > MAX_WORDS;
    assign last_word = cnt + 32'd1 == len;
    assign tx_valid  = state == S_ACK;
    assign cpu_start = state == S_DONE;
    assign busy      = state == S_DATA || state == S_CSUM || state == S_ACK || (state == S_LEN && bidx != 2'd0);
    always_comb begin
        state_nx = state;
        case (state)
            S_LEN:   if (rx_valid && bidx == 2'd3) state_nx = len_bad ? S_ACK : (len_full == 32'd0 ? S_CSUM : S_DATA);
            S_DATA:  if (rx_valid && bidx == 2'd3 && last_word) state_nx = S_CSUM;
            S_CSUM:  if (rx_valid) state_nx = S_ACK;
            S_ACK:   if (tx_ready) state_nx = ok_r ? S_DONE : S_LEN;
            default: state_nx = state;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_LEN;
            len        <= '0;
            cnt        <= '0;
            buf_w      <= '0;
            acc        <= '0;
            bidx       <= '0;
            ok_r       <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            tx_data    <= '0;
            error      <= 1'b0;
        end else begin
            state   <= state_nx;
            imem_we <= 1'b0;
            if (rx_valid && (state == S_LEN || state == S_DATA)) bidx <= bidx + 2'd1;
            if (rx_valid && state == S_LEN) begin
                len <= len_full;
                if (bidx == 2'd0) error <= 1'b0;
                if (bidx == 2'd3 && len_bad) begin
                    tx_data <= ACK_ERR;
                    ok_r    <= 1'b0;
                end
            end
            // low three bytes shift in; the fourth completes the word directly
            if (rx_valid && state == S_DATA) begin
                acc   <= acc ^ rx_data;
                buf_w <= {rx_data, buf_w[23:8]};
                if (bidx == 2'd3) begin
                    imem_we    <= 1'b1;
                    imem_wdata <= word;
                    imem_addr  <= cnt[ADDR_W-1:0];
                    cnt        <= cnt + 32'd1;
                end
            end
            if (rx_valid && state == S_CSUM) begin
                ok_r    <= rx_data == acc;
                tx_data <= rx_data == acc ? ACK_OK : ACK_ERR;
            end
            if (state == S_ACK && tx_ready && !ok_r) begin
                error     <= 1'b1;
                cnt       <= '0;
                acc       <= '0;
                len       <= '0;
                imem_addr <= '0;
            end
        end
    end
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: directed-vector bench for program_loader with a write log of imem traffic.
module tb_program_loader;
    localparam int ADDR_W = 14;
    logic clk = 1'b0, rst = 1'b1, rx_valid = 1'b0, tx_ready = 1'b1;
    logic [7:0] rx_data = '0;
    logic tx_valid, imem_we, busy, cpu_start, error;
    logic [7:0] tx_data;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0] imem_wdata;
    int vectors = 0, miscompares = 0, hs_cnt = 0, mark = 0, h0 = 0;
    logic [31:0] wa[$], wd[$];
    logic [31:0] img[16];
    logic [7:0] d, cs;
    bit b2b = 1'b0;

    program_loader #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data), .tx_ready(tx_ready),
        .tx_valid(tx_valid), .tx_data(tx_data), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .busy(busy), .cpu_start(cpu_start), .error(error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (imem_we) begin
            wa.push_back(32'(imem_addr));
            wd.push_back(imem_wdata);
        end
        if (tx_valid && tx_ready) hs_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset;
        rst = 1'b1;
        rx_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data = b;
        if (!b2b) begin
            @(negedge clk);
            rx_valid = 1'b0;
        end
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) send(w[8*k +: 8]);
    endtask

    task automatic send_frame(input logic [31:0] n, input int nw, input logic [7:0] c);
        send_word(n);
        for (int i = 0; i < nw; i++) send_word(img[i]);
        send(c);
        if (b2b) begin
            @(negedge clk);
            rx_valid = 1'b0;
        end
    endtask

    task automatic wait_ack(output logic [7:0] ack);
        int i = 0;
        while (!tx_valid && i < 100) begin
            @(negedge clk);
            i++;
        end
        chk("ack_seen", 32'(tx_valid), 32'd1);
        ack = tx_data;
    endtask

    initial begin
        do_reset;
        chk("rst_tx_valid", 32'(tx_valid), 0);
        chk("rst_tx_data", 32'(tx_data), 0);
        chk("rst_imem_we", 32'(imem_we), 0);
        chk("rst_imem_addr", 32'(imem_addr), 0);
        chk("rst_imem_wdata", imem_wdata, 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_cpu_start", 32'(cpu_start), 0);
        chk("rst_error", 32'(error), 0);

        // nop + addi x1,x0,1: byte XOR 0x13^0x93^0x10 = 0x90
        img[0] = 32'h00000013;
        img[1] = 32'h00100093;
        mark = wa.size();
        send_word(32'd2);
        chk("t1_busy", 32'(busy), 1);
        send_word(img[0]);
        chk("t1_we_latency", 32'(imem_we), 1);
        chk("t1_we_addr", 32'(imem_addr), 0);
        chk("t1_we_data", imem_wdata, 32'h00000013);
        send_word(img[1]);
        send(8'h90);
        wait_ack(d);
        chk("t1_ack", 32'(d), 32'hAA);
        @(negedge clk);
        chk("t1_tx_valid_off", 32'(tx_valid), 0);
        chk("t1_cpu_start", 32'(cpu_start), 1);
        chk("t1_busy_off", 32'(busy), 0);
        chk("t1_nwrites", 32'(wa.size() - mark), 2);
        chk("t1_a0", wa[mark], 0);
        chk("t1_d0", wd[mark], 32'h00000013);
        chk("t1_a1", wa[mark+1], 1);
        chk("t1_d1", wd[mark+1], 32'h00100093);

        do_reset;
        chk("t2_rst_cpu_start", 32'(cpu_start), 0);
        mark = wa.size();
        send_frame(2, 2, 8'h00);
        wait_ack(d);
        chk("t2_ack_err", 32'(d), 32'h55);
        @(negedge clk);
        chk("t2_error", 32'(error), 1);
        chk("t2_cpu_start", 32'(cpu_start), 0);
        chk("t2_busy", 32'(busy), 0);
        chk("t2_nwrites", 32'(wa.size() - mark), 2);
        mark = wa.size();
        send(8'h02);
        chk("t2_err_clear", 32'(error), 0);
        send(8'h00); send(8'h00); send(8'h00);
        send_word(img[0]);
        send_word(img[1]);
        send(8'h90);
        wait_ack(d);
        chk("t2_retry_ack", 32'(d), 32'hAA);
        @(negedge clk);
        chk("t2_retry_cpu_start", 32'(cpu_start), 1);
        chk("t2_retry_error", 32'(error), 0);
        chk("t2_retry_a0", wa[mark], 0);
        chk("t2_retry_a1", wa[mark+1], 1);
        chk("t2_retry_d1", wd[mark+1], 32'h00100093);

        do_reset;
        mark = wa.size();
        send_frame(0, 0, 8'h00);
        wait_ack(d);
        chk("t3_empty_ack", 32'(d), 32'hAA);
        @(negedge clk);
        chk("t3_empty_cpu_start", 32'(cpu_start), 1);
        chk("t3_empty_nwrites", 32'(wa.size() - mark), 0);
        do_reset;
        send_word(32'd16385);
        chk("t3_len_err_valid", 32'(tx_valid), 1);
        chk("t3_len_err_data", 32'(tx_data), 32'h55);
        @(negedge clk);
        chk("t3_len_err_flag", 32'(error), 1);
        chk("t3_len_err_nwrites", 32'(wa.size() - mark), 0);

        do_reset;
        tx_ready = 1'b0;
        send_frame(2, 2, 8'h90);
        wait_ack(d);
        chk("t4_ack", 32'(d), 32'hAA);
        h0 = hs_cnt;
        mark = wa.size();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            rx_valid = 1'b1;
            rx_data = 8'(i);
            chk("t4_hold_valid", 32'(tx_valid), 1);
            chk("t4_hold_data", 32'(tx_data), 32'hAA);
        end
        @(negedge clk);
        rx_valid = 1'b0;
        tx_ready = 1'b1;
        @(negedge clk);
        chk("t4_one_hs", 32'(hs_cnt - h0), 1);
        chk("t4_valid_off", 32'(tx_valid), 0);
        repeat (3) @(negedge clk);
        chk("t4_still_one_hs", 32'(hs_cnt - h0), 1);
        chk("t4_no_writes", 32'(wa.size() - mark), 0);
        chk("t4_cpu_start", 32'(cpu_start), 1);

        do_reset;
        mark = wa.size();
        send_word(32'd2);
        send(8'h13);
        send(8'h00);
        rst = 1'b1;
        @(negedge clk);
        chk("t5_busy", 32'(busy), 0);
        chk("t5_tx_valid", 32'(tx_valid), 0);
        chk("t5_imem_we", 32'(imem_we), 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("t5_no_partial", 32'(wa.size() - mark), 0);
        send_frame(2, 2, 8'h90);
        wait_ack(d);
        chk("t5_ack", 32'(d), 32'hAA);
        chk("t5_a0", wa[mark], 0);
        chk("t5_d0", wd[mark], 32'h00000013);
        chk("t5_d1", wd[mark+1], 32'h00100093);

        do_reset;
        cs = 8'h00;
        for (int i = 0; i < 16; i++) begin
            img[i] = {12'(i), 5'd0, 3'd0, 5'(i), 7'h13};
            cs = cs ^ img[i][7:0] ^ img[i][15:8] ^ img[i][23:16] ^ img[i][31:24];
        end
        b2b = 1'b1;
        mark = wa.size();
        send_frame(16, 16, cs);
        wait_ack(d);
        chk("t6_ack", 32'(d), 32'hAA);
        chk("t6_nwrites", 32'(wa.size() - mark), 16);
        for (int i = 0; i < 16; i++) begin
            chk("t6_addr", wa[mark+i], 32'(i));
            chk("t6_data", wd[mark+i], img[i]);
        end
        b2b = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
